// File: rtl/sonic_poll_scheduler.sv
// -----------------------------------------------------------------------------
// sonic_poll_scheduler
//   Avalon-MM master that drives the ultrasonic ranging core through one
//   measurement: write CTRL=1 (trigger), wait a settle time, poll STATUS until
//   bit0 is set (or give up after a timeout), read DIST, then publish a
//   saturated distance with a one-cycle valid strobe. Measurements run
//   periodically while enable is high, or once per start pulse.
//
//   Optional build macro: MEDIAN3_EN
//     defined   : published distance is the median of the last three saturated
//                 samples (the first two after reset are passed through raw).
//     undefined : published distance is the raw saturated sample.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   enable              1 = periodic auto measurement every PERIOD_CYCLES
//   start               single-cycle request for one measurement
//   s_address/s_cs/s_read/s_write/s_writedata
//                       master command to the sonic slave (0=DIST 1=CTRL 2=STATUS)
//   s_readdata          read data, valid the cycle after a read is accepted
//   s_waitrequest       slave stall; a command is accepted when it is low
//   distance            last good distance, held between updates
//   distance_valid      one-cycle pulse while distance takes its new value
//   sensor_timeout      set when polling gives up, cleared by the next publish
//   overrun             sticky: a period tick arrived while busy; start clears
//   busy                high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module sonic_poll_scheduler #(
   parameter int PERIOD_CYCLES  = 3_000_000,
   parameter int SETTLE_CYCLES  = 500,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int DIST_W         = 22
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              start,
   output logic [2:0]        s_address,
   output logic              s_cs,
   output logic              s_read,
   output logic              s_write,
   output logic [31:0]       s_writedata,
   input  logic [31:0]       s_readdata,
   input  logic              s_waitrequest,
   output logic [DIST_W-1:0] distance,
   output logic              distance_valid,
   output logic              sensor_timeout,
   output logic              overrun,
   output logic              busy
);

   localparam int TMR_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int PER_W   = $clog2(PERIOD_CYCLES + 1);

   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_LAST    = PER_W'(PERIOD_CYCLES - 1);

   localparam logic [2:0] ADDR_DIST   = 3'd0;
   localparam logic [2:0] ADDR_CTRL   = 3'd1;
   localparam logic [2:0] ADDR_STATUS = 3'd2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TRIG    = 3'd1,
      SETTLE  = 3'd2,
      POLL    = 3'd3,
      RD_DIST = 3'd4,
      PUBLISH = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic                rdwait_q, rdwait_d;     // 0: issuing read, 1: read data on bus
   logic [TMR_W-1:0]    tmr_q, tmr_d;           // settle count, then poll timeout count
   logic [PER_W-1:0]    per_q, per_d;
   logic                pending_q, pending_d;
   logic                overrun_q, overrun_d;
   logic                timeout_q, timeout_d;
   logic [DIST_W-1:0]   dist_q, dist_d;

   logic                tick;
   logic [DIST_W-1:0]   sat_w;
   logic [DIST_W-1:0]   filtered;

   // Period counter only advances while enabled; tick on the last count, then wrap.
   assign tick  = enable && (per_q == PER_LAST);
   assign per_d = (!enable || tick) ? '0 : per_q + PER_W'(1);

   // Any set bit above the published width means the reading does not fit.
   assign sat_w = (|s_readdata[31:DIST_W]) ? '1 : s_readdata[DIST_W-1:0];

`ifdef MEDIAN3_EN
   logic [DIST_W-1:0] h1_q, h2_q;   // previous two saturated samples, newest in h1
   logic [1:0]        hcnt_q;       // number of valid history entries (0..2)
   logic              pub_take;

   function automatic logic [DIST_W-1:0] med3(input logic [DIST_W-1:0] a,
                                              input logic [DIST_W-1:0] b,
                                              input logic [DIST_W-1:0] c);
      logic [DIST_W-1:0] lo, hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (c < lo)      return lo;
      else if (c > hi) return hi;
      else             return c;
   endfunction

   // A sample enters history only on a successful DIST read; timeouts never reach here.
   assign pub_take = (state_q == RD_DIST) && rdwait_q;
   assign filtered = (hcnt_q == 2'd2) ? med3(sat_w, h1_q, h2_q) : sat_w;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h1_q   <= '0;
         h2_q   <= '0;
         hcnt_q <= '0;
      end else if (pub_take) begin
         h1_q <= sat_w;
         h2_q <= h1_q;
         if (hcnt_q != 2'd2) hcnt_q <= hcnt_q + 2'd1;
      end
   end
`else
   assign filtered = sat_w;
`endif

   always_comb begin
      state_d     = state_q;
      rdwait_d    = rdwait_q;
      tmr_d       = tmr_q;
      pending_d   = pending_q;
      overrun_d   = overrun_q;
      timeout_d   = timeout_q;
      dist_d      = dist_q;
      s_read      = 1'b0;
      s_write     = 1'b0;
      s_address   = ADDR_DIST;

      case (state_q)
         IDLE: begin
            if (start || tick || pending_q) begin
               state_d   = TRIG;
               pending_d = 1'b0;
            end
         end
         TRIG: begin
            s_write   = 1'b1;
            s_address = ADDR_CTRL;
            if (!s_waitrequest) begin
               state_d = SETTLE;
               tmr_d   = '0;
            end
         end
         SETTLE: begin
            if (tmr_q == SETTLE_LAST) begin
               state_d  = POLL;
               tmr_d    = '0;
               rdwait_d = 1'b0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         POLL: begin
            // Timer saturates so an expiry during a stalled read is still seen
            // at the next data phase; a command is never abandoned mid-stall.
            if (tmr_q != TMO_LAST) tmr_d = tmr_q + TMR_W'(1);
            if (!rdwait_q) begin
               s_read    = 1'b1;
               s_address = ADDR_STATUS;
               if (!s_waitrequest) rdwait_d = 1'b1;
            end else if (s_readdata[0]) begin
               state_d  = RD_DIST;
               rdwait_d = 1'b0;
            end else if (tmr_q == TMO_LAST) begin
               state_d   = IDLE;
               rdwait_d  = 1'b0;
               timeout_d = 1'b1;
            end else begin
               rdwait_d = 1'b0;
            end
         end
         RD_DIST: begin
            if (!rdwait_q) begin
               s_read    = 1'b1;
               s_address = ADDR_DIST;
               if (!s_waitrequest) rdwait_d = 1'b1;
            end else begin
               // Register the result now so it is on distance during PUBLISH.
               state_d   = PUBLISH;
               rdwait_d  = 1'b0;
               dist_d    = filtered;
               timeout_d = 1'b0;
            end
         end
         PUBLISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Ticks while busy collapse into a single pending request.
      if (state_q != IDLE) begin
         if (start) overrun_d = 1'b0;
         if (tick) begin
            pending_d = 1'b1;
            overrun_d = 1'b1;
         end
      end
      if (!enable) pending_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rdwait_q  <= 1'b0;
         tmr_q     <= '0;
         per_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         dist_q    <= '0;
      end else begin
         state_q   <= state_d;
         rdwait_q  <= rdwait_d;
         tmr_q     <= tmr_d;
         per_q     <= per_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         dist_q    <= dist_d;
      end
   end

   // Strobes are decoded from registered state, so reset removes them at once.
   assign s_cs           = s_read | s_write;
   assign s_writedata    = s_write ? 32'd1 : 32'd0;
   assign distance       = dist_q;
   assign distance_valid = (state_q == PUBLISH);
   assign sensor_timeout = timeout_q;
   assign overrun        = overrun_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_sonic_poll_scheduler.sv
`timescale 1ns/1ps
module tb_sonic_poll_scheduler;
   localparam int P = 50;
   localparam int S = 40;
   localparam int T = 100;
   localparam int W = 22;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    s_address;
   logic          s_cs, s_read, s_write;
   logic [31:0]   s_writedata;
   logic [31:0]   s_readdata = 32'd0;
   logic          s_waitrequest;
   logic [W-1:0]  distance;
   logic          distance_valid, sensor_timeout, overrun, busy;

   sonic_poll_scheduler #(
      .PERIOD_CYCLES(P), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .DIST_W(W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
      .s_address(s_address), .s_cs(s_cs), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
      .distance(distance), .distance_valid(distance_valid),
      .sensor_timeout(sensor_timeout), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // slave behaviour knobs, written only by the test tasks
   int           wait_n = 0;
   int           done_after = 1;   // STATUS done on this poll of a measurement; 0 = never
   logic [31:0]  dist_val = 32'd0;

   // slave bookkeeping
   int          stall_cnt = 0, poll_cnt = 0;
   int          n_wr = 0, n_bad_wr = 0, n_poll = 0, n_drd = 0;
   int          n_unstable = 0, n_proto = 0, n_valid = 0, n_pubto = 0;
   logic        held_vld = 1'b0;
   logic [36:0] held = '0;
   logic [31:0] sup_q[$];
   logic [W-1:0] obs_q[$];

   // reference model state
   logic [W-1:0] hist[$];
   logic [W-1:0] exp_last = '0;

   assign s_waitrequest = (s_read | s_write) && (stall_cnt < wait_n);

   always @(posedge clk) begin
      logic [31:0] r;
      r = $urandom;
      if (!reset_n) begin
         held_vld   <= 1'b0;
         stall_cnt  <= 0;
         s_readdata <= r;
      end else begin
         if (held_vld && ({s_address, s_read, s_write, s_writedata} != held))
            n_unstable <= n_unstable + 1;
         if ((s_cs !== (s_read | s_write)) || (s_read && s_write) || (!s_write && s_writedata != 32'd0))
            n_proto <= n_proto + 1;
         s_readdata <= r;   // junk unless a read was just accepted
         held_vld   <= 1'b0;
         if (s_read | s_write) begin
            if (s_waitrequest) begin
               stall_cnt <= stall_cnt + 1;
               held_vld  <= 1'b1;
               held      <= {s_address, s_read, s_write, s_writedata};
            end else begin
               stall_cnt <= 0;
               if (s_write) begin
                  n_wr     <= n_wr + 1;
                  poll_cnt <= 0;
                  if (s_address != 3'd1 || s_writedata != 32'd1) n_bad_wr <= n_bad_wr + 1;
               end else if (s_address == 3'd2) begin
                  n_poll     <= n_poll + 1;
                  poll_cnt   <= poll_cnt + 1;
                  s_readdata <= (r & ~32'd1) |
                                ((done_after != 0 && poll_cnt + 1 >= done_after) ? 32'd1 : 32'd0);
               end else if (s_address == 3'd0) begin
                  n_drd      <= n_drd + 1;
                  s_readdata <= dist_val;
                  sup_q.push_back(dist_val);
               end else begin
                  n_proto <= n_proto + 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && distance_valid) begin
         n_valid <= n_valid + 1;
         obs_q.push_back(distance);
         if (sensor_timeout) n_pubto <= n_pubto + 1;
      end
   end

   // Expected published value: saturate to W bits, then optionally median-of-3.
   function automatic logic [W-1:0] model_dist(input logic [31:0] raw);
      logic [W-1:0] s, a, b, c, m;
      s = ((raw >> W) != 0) ? {W{1'b1}} : raw[W-1:0];
`ifdef MEDIAN3_EN
      hist.push_back(s);
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() < 3) m = s;
      else begin
         a = hist[0]; b = hist[1]; c = hist[2];
         m = (a > b) ? ((b > c) ? b : ((a > c) ? c : a))
                     : ((a > c) ? a : ((b > c) ? c : b));
      end
`else
      m = s;
`endif
      exp_last = m;
      return m;
   endfunction

   task automatic do_measure(output bit ok);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (!busy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (distance !== '0) begin n_err++; $display("FAIL reset_distance got=%0h exp=0", distance); end
      n_vec++; if ({distance_valid, sensor_timeout, overrun} !== 3'b000) begin
         n_err++; $display("FAIL reset_flags got=%b exp=000", {distance_valid, sensor_timeout, overrun}); end
      n_vec++; if ({s_cs, s_read, s_write} !== 3'b000) begin
         n_err++; $display("FAIL reset_strobes got=%b exp=000", {s_cs, s_read, s_write}); end
      n_vec++; if (s_writedata !== 32'd0) begin n_err++; $display("FAIL reset_wdata got=%0h exp=0", s_writedata); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic(input int wn, input string tag);
      int w0, p0, d0, v0;
      bit ok;
      logic [W-1:0] got, exp;
      w0 = n_wr; p0 = n_poll; d0 = n_drd; v0 = n_valid;
      wait_n = wn; done_after = 1; dist_val = 32'd1234;
      do_measure(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL %s_done busy stuck exp=idle", tag); end
      n_vec++; if (n_wr - w0 != 1 || n_bad_wr != 0) begin
         n_err++; $display("FAIL %s_trig writes=%0d bad=%0d exp=1/0", tag, n_wr - w0, n_bad_wr); end
      n_vec++; if (n_poll - p0 != 1 || n_drd - d0 != 1) begin
         n_err++; $display("FAIL %s_reads polls=%0d dist=%0d exp=1/1", tag, n_poll - p0, n_drd - d0); end
      n_vec++; if (n_valid - v0 != 1) begin n_err++; $display("FAIL %s_valid pulses=%0d exp=1", tag, n_valid - v0); end
      n_vec++; if (distance !== W'(1234)) begin n_err++; $display("FAIL %s_dist got=%0d exp=1234", tag, distance); end
      n_vec++; if (n_unstable != 0 || n_proto != 0) begin
         n_err++; $display("FAIL %s_bus unstable=%0d proto=%0d exp=0/0", tag, n_unstable, n_proto); end
      while (obs_q.size() != 0 && sup_q.size() != 0) begin
         exp = model_dist(sup_q.pop_front()); got = obs_q.pop_front();
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL %s_model got=%0h exp=%0h", tag, got, exp); end
      end
   endtask

   task automatic test_timeout();
      int p0, v0;
      bit ok;
      logic [W-1:0] got, exp;
      p0 = n_poll; v0 = n_valid;
      wait_n = 0; done_after = 0; dist_val = 32'd777;
      do_measure(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL timeout_done busy stuck exp=idle"); end
      n_vec++; if (sensor_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag got=%b exp=1", sensor_timeout); end
      n_vec++; if (n_valid != v0) begin n_err++; $display("FAIL timeout_valid pulses=%0d exp=0", n_valid - v0); end
      n_vec++; if (distance !== exp_last) begin n_err++; $display("FAIL timeout_hold got=%0h exp=%0h", distance, exp_last); end
      n_vec++; if (n_poll - p0 < T/2 - 1 || n_poll - p0 > T/2 + 1) begin
         n_err++; $display("FAIL timeout_polls got=%0d exp=%0d+-1", n_poll - p0, T/2); end
      done_after = 1; dist_val = 32'($urandom_range(0, 4000000));
      do_measure(ok);
      n_vec++; if (sensor_timeout !== 1'b0 || n_pubto != 0) begin
         n_err++; $display("FAIL timeout_clear got=%b pubto=%0d exp=0/0", sensor_timeout, n_pubto); end
      while (obs_q.size() != 0 && sup_q.size() != 0) begin
         exp = model_dist(sup_q.pop_front()); got = obs_q.pop_front();
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL timeout_model got=%0h exp=%0h", got, exp); end
      end
   endtask

   task automatic test_saturation();
      logic [31:0]  vals [4];
      logic [W-1:0] cons [4];
      logic [W-1:0] got, exp;
      bit ok;
      vals[0] = 32'h0040_0000; cons[0] = 22'h3F_FFFF;
      vals[1] = 32'h003F_FFFF; cons[1] = 22'h3F_FFFF;
      vals[2] = 32'hFFFF_FFFF; cons[2] = 22'h3F_FFFF;
      vals[3] = 32'h0012_3456; cons[3] = 22'h12_3456;
      wait_n = 0; done_after = 2;
      for (int i = 0; i < 4; i++) begin
         dist_val = vals[i];
         // three identical samples make the median equal the raw saturated value
         for (int j = 0; j < 3; j++) do_measure(ok);
         n_vec++; if (distance !== cons[i]) begin
            n_err++; $display("FAIL sat_%0d got=%0h exp=%0h", i, distance, cons[i]); end
         while (obs_q.size() != 0 && sup_q.size() != 0) begin
            exp = model_dist(sup_q.pop_front()); got = obs_q.pop_front();
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL sat_model got=%0h exp=%0h", got, exp); end
         end
      end
   endtask

   task automatic test_random();
      int p0;
      bit ok;
      logic [W-1:0] got, exp;
      for (int i = 0; i < 10; i++) begin
         wait_n = $urandom_range(0, 3);
         done_after = $urandom_range(1, 4);
         dist_val = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, (1 << W) - 1));
         p0 = n_poll;
         do_measure(ok);
         n_vec++; if (!ok || n_poll - p0 != done_after) begin
            n_err++; $display("FAIL rand_%0d polls=%0d exp=%0d ok=%0d", i, n_poll - p0, done_after, ok); end
         n_vec++; if (obs_q.size() != sup_q.size()) begin
            n_err++; $display("FAIL rand_cnt pubs=%0d exp=%0d", obs_q.size(), sup_q.size()); end
         while (obs_q.size() != 0 && sup_q.size() != 0) begin
            exp = model_dist(sup_q.pop_front()); got = obs_q.pop_front();
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL rand_model got=%0h exp=%0h", got, exp); end
         end
      end
      n_vec++; if (n_unstable != 0 || n_proto != 0) begin
         n_err++; $display("FAIL rand_bus unstable=%0d proto=%0d exp=0/0", n_unstable, n_proto); end
   endtask

   task automatic test_periodic();
      int v0, nbusy;
      bit seen;
      logic [W-1:0] got, exp;
      v0 = n_valid;
      wait_n = 2; done_after = 4; dist_val = 32'($urandom_range(0, 100000));
      @(negedge clk); enable = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin @(negedge clk); seen = overrun; end
      n_vec++; if (!seen) begin n_err++; $display("FAIL per_overrun got=0 exp=1"); end
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin @(negedge clk); seen = distance_valid; end
      n_vec++; if (!seen) begin n_err++; $display("FAIL per_first_pub got=none exp=pulse"); end
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL per_idle_gap got=%b exp=0", busy); end
      @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL per_back2back got=%b exp=1", busy); end
      start = 1'b1; @(negedge clk); start = 1'b0; enable = 1'b0;
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL per_start_clr got=%b exp=0", overrun); end
      seen = 1'b0;
      for (int k = 0; k < 300 && !seen; k++) begin @(negedge clk); seen = !busy; end
      n_vec++; if (!seen) begin n_err++; $display("FAIL per_finish busy stuck exp=idle"); end
      nbusy = 0;
      for (int k = 0; k < 120; k++) begin @(negedge clk); if (busy) nbusy++; end
      n_vec++; if (nbusy != 0 || n_valid - v0 != 2) begin
         n_err++; $display("FAIL per_stop busycyc=%0d pubs=%0d exp=0/2", nbusy, n_valid - v0); end
      while (obs_q.size() != 0 && sup_q.size() != 0) begin
         exp = model_dist(sup_q.pop_front()); got = obs_q.pop_front();
         n_vec++; if (got !== exp) begin n_err++; $display("FAIL per_model got=%0h exp=%0h", got, exp); end
      end
   endtask

   task automatic test_median_reset();
      logic [31:0]  smp [4];
      logic [W-1:0] got, exp;
      bit ok, seen;
      wait_n = 0; done_after = 0;
      @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin @(negedge clk); seen = s_read && (s_address == 3'd2); end
      n_vec++; if (!seen) begin n_err++; $display("FAIL rst_poll_reach got=none exp=status read"); end
      #2 reset_n = 1'b0;
      #1;
      n_vec++; if ({s_cs, s_read, s_write} !== 3'b000) begin
         n_err++; $display("FAIL rst_async_strobes got=%b exp=000", {s_cs, s_read, s_write}); end
      n_vec++; if (busy !== 1'b0 || distance !== '0 || sensor_timeout !== 1'b0 || overrun !== 1'b0) begin
         n_err++; $display("FAIL rst_async_outs busy=%b dist=%0h to=%b ov=%b exp=0", busy, distance, sensor_timeout, overrun); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      hist.delete(); exp_last = '0;
      smp[0] = 32'd100; smp[1] = 32'd900; smp[2] = 32'd300; smp[3] = 32'd50;
      done_after = 1;
      for (int i = 0; i < 4; i++) begin
         dist_val = smp[i];
         do_measure(ok);
         if (i < 3) begin
            n_vec++; if (distance !== W'(smp[i])) begin
               n_err++; $display("FAIL med_seq_%0d got=%0d exp=%0d", i, distance, smp[i]); end
         end
         while (obs_q.size() != 0 && sup_q.size() != 0) begin
            exp = model_dist(sup_q.pop_front()); got = obs_q.pop_front();
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL med_model got=%0h exp=%0h", got, exp); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic(0, "basic");
      test_basic(3, "waitreq");
      test_timeout();
      test_saturation();
      test_random();
      test_periodic();
      test_median_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end
endmodule
